uart_tx_scheduler: RTL and testbench

//   Shares one UART transmitter between NUM_REQ byte producers.
//   - Round-robin arbitration among requesters.
//   - Drives the transmitter's tx_start/data_in/parity_en/even_parity and tracks tx_busy.
//   - Enforces a minimum idle gap between frames.
//   - Flags a transmitter that never acknowledges a start.

---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 129 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
// Imported by the arbiter and the scheduler top.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } sched_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value n itself; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or after ptr wins,
// wrapping around the requester ring.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int  N = 4,
    localparam int W = id_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    assign any = |req;

    always_comb begin
        int   j;
        logic hit;
        gnt_onehot = '0;
        gnt_idx    = '0;
        hit        = 1'b0;
        j          = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!hit && req[j]) begin
                hit           = 1'b1;
                gnt_onehot[j] = 1'b1;
                gnt_idx       = W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers with
// round-robin grants, an inter-frame gap and a start-acknowledge timeout.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  GAP_CYCLES  = 2,
    parameter int  ACK_TIMEOUT = 16,
    localparam int IDW         = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_even_par,
    output logic                 tx_start,
    output logic [7:0]           data_in,
    output logic                 parity_en,
    output logic                 even_parity,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    localparam int ACW = cnt_width(ACK_TIMEOUT);
    localparam int GCW = cnt_width(GAP_CYCLES);

    sched_state_t state_q, state_d;

    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               any_req;
    logic               accept;
    logic               ack_expired;
    logic               gap_done;
    logic [ACW-1:0]     ack_cnt;
    logic [GCW-1:0]     gap_cnt;
    logic [7:0]         sel_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_oh),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    // A busy transmitter in IDLE belongs to someone else: hold off.
    assign accept      = (state_q == IDLE) && !rst && !tx_busy && any_req;
    assign req_ready   = accept ? gnt_oh : '0;
    assign active      = (state_q != IDLE);
    assign ack_expired = (ack_cnt == ACW'(ACK_TIMEOUT - 1));
    assign gap_done    = (GAP_CYCLES == 0) ||
                         (gap_cnt == GCW'(GAP_CYCLES - 1));

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) sel_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        tx_start    = 1'b0;
        err_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = LAUNCH;
            end
            LAUNCH: begin
                tx_start = 1'b1;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_expired) begin
                    err_timeout = 1'b1;
                    state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            ack_cnt <= (state_q == WAIT_ACK) ? ack_cnt + ACW'(1) : '0;
            gap_cnt <= (state_q == GAP) ? gap_cnt + GCW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_in     <= '0;
            parity_en   <= 1'b0;
            even_parity <= 1'b0;
            grant_id    <= '0;
            ptr_q       <= '0;
        end else if (accept) begin
            data_in     <= sel_data;
            parity_en   <= cfg_parity_en;
            even_parity <= cfg_even_par;
            grant_id    <= gnt_idx;
            ptr_q       <= (gnt_idx == IDW'(NUM_REQ - 1)) ?
                           '0 : gnt_idx + IDW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: directed stimulus queues expected accepts, launches
// and timeouts; negedge monitors compare whenever the DUTs present them.
module tb_uart_tx_scheduler;

    typedef struct {
        int         cyc;
        logic [3:0] rdy;
    } acc_t;

    typedef struct {
        int         cyc;
        logic [1:0] id;
        logic [7:0] data;
        logic       pe;
        logic       ep;
    } lau_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_valid0;
    logic [31:0] req_data;
    logic        pe, ep;

    logic [3:0]  req_ready, req_ready0;
    logic        tx_start, tx_start0;
    logic [7:0]  data_in, data_in0;
    logic        parity_en, parity_en0;
    logic        even_parity, even_parity0;
    logic        tx_busy, tx_busy0;
    logic [1:0]  grant_id, grant_id0;
    logic        active, active0;
    logic        err_timeout, err_timeout0;

    logic [3:0]  bcnt = '0;
    logic [3:0]  bcnt0 = '0;
    logic        ack_en = 1'b1;
    logic        force_busy = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    acc_t acc_q[$];
    lau_t lau_q[$];
    int   err_q[$];
    acc_t acc0_q[$];
    lau_t lau0_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_parity_en(pe), .cfg_even_par(ep),
        .tx_start(tx_start), .data_in(data_in),
        .parity_en(parity_en), .even_parity(even_parity),
        .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .err_timeout(err_timeout)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_data(req_data), .req_ready(req_ready0),
        .cfg_parity_en(pe), .cfg_even_par(ep),
        .tx_start(tx_start0), .data_in(data_in0),
        .parity_en(parity_en0), .even_parity(even_parity0),
        .tx_busy(tx_busy0), .grant_id(grant_id0),
        .active(active0), .err_timeout(err_timeout0)
    );

    // Transmitter model: busy from the start strobe for 10 cycles.
    always @(posedge clk) begin
        if (tx_start && ack_en) bcnt <= 4'd9;
        else if (bcnt != 0)     bcnt <= bcnt - 4'd1;
        if (tx_start0)          bcnt0 <= 4'd9;
        else if (bcnt0 != 0)    bcnt0 <= bcnt0 - 4'd1;
    end

    assign tx_busy  = force_busy | (ack_en & (tx_start | (bcnt != 0)));
    assign tx_busy0 = tx_start0 | (bcnt0 != 0);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_acc(input int c, input logic [3:0] r);
        acc_q.push_back('{cyc: c, rdy: r});
    endtask

    task automatic exp_lau(input int c, input logic [1:0] id,
                           input logic [7:0] d, input logic p, input logic e);
        lau_q.push_back('{cyc: c, id: id, data: d, pe: p, ep: e});
    endtask

    task automatic exp_acc0(input int c, input logic [3:0] r);
        acc0_q.push_back('{cyc: c, rdy: r});
    endtask

    task automatic exp_lau0(input int c, input logic [1:0] id,
                            input logic [7:0] d, input logic p, input logic e);
        lau0_q.push_back('{cyc: c, id: id, data: d, pe: p, ep: e});
    endtask

    always @(negedge clk) begin : mon
        acc_t a;
        lau_t l;
        int   ec;
        if (req_ready != 0) begin
            if (acc_q.size() == 0) begin
                chk("ready_unexpected", 32'(req_ready), 32'h0);
            end else begin
                a = acc_q.pop_front();
                chk("ready_vec", 32'(req_ready), 32'(a.rdy));
                chk("ready_cyc", cyc, a.cyc);
            end
        end
        if (tx_start) begin
            if (lau_q.size() == 0) begin
                chk("start_unexpected", 32'(tx_start), 32'h0);
            end else begin
                l = lau_q.pop_front();
                chk("start_cyc", cyc, l.cyc);
                chk("grant_id", 32'(grant_id), 32'(l.id));
                chk("data_in", 32'(data_in), 32'(l.data));
                chk("parity", {30'h0, parity_en, even_parity}, {30'h0, l.pe, l.ep});
            end
        end
        if (err_timeout) begin
            if (err_q.size() == 0) begin
                chk("timeout_unexpected", 32'(err_timeout), 32'h0);
            end else begin
                ec = err_q.pop_front();
                chk("timeout_cyc", cyc, ec);
            end
        end
    end

    always @(negedge clk) begin : mon0
        acc_t a;
        lau_t l;
        if (req_ready0 != 0) begin
            if (acc0_q.size() == 0) begin
                chk("g0_ready_unexpected", 32'(req_ready0), 32'h0);
            end else begin
                a = acc0_q.pop_front();
                chk("g0_ready_vec", 32'(req_ready0), 32'(a.rdy));
                chk("g0_ready_cyc", cyc, a.cyc);
            end
        end
        if (tx_start0) begin
            if (lau0_q.size() == 0) begin
                chk("g0_start_unexpected", 32'(tx_start0), 32'h0);
            end else begin
                l = lau0_q.pop_front();
                chk("g0_start_cyc", cyc, l.cyc);
                chk("g0_grant_id", 32'(grant_id0), 32'(l.id));
                chk("g0_data_in", 32'(data_in0), 32'(l.data));
                chk("g0_parity", {30'h0, parity_en0, even_parity0},
                    {30'h0, l.pe, l.ep});
            end
        end
        if (err_timeout0) chk("g0_timeout_unexpected", 32'(err_timeout0), 32'h0);
    end

    initial begin : stim
        int c;
        rst        = 1'b1;
        req_valid  = '0;
        req_valid0 = '0;
        req_data   = '0;
        pe         = 1'b0;
        ep         = 1'b0;
        step(3);
        chk("reset_outputs",
            {13'h0, tx_start, req_ready, err_timeout, active, data_in,
             parity_en, even_parity, grant_id}, 32'h0);
        chk("reset_outputs_g0",
            {13'h0, tx_start0, req_ready0, err_timeout0, active0, data_in0,
             parity_en0, even_parity0, grant_id0}, 32'h0);
        rst = 1'b0;
        step(1);

        // Single request, parity config latched at accept.
        c = cyc;
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        pe = 1'b1;
        ep = 1'b1;
        exp_acc(c, 4'b0100);
        exp_lau(c + 1, 2'd2, 8'hA5, 1'b1, 1'b1);
        step(1);
        req_valid = '0;
        pe = 1'b0;
        ep = 1'b0;
        step(13);

        // Reset while the transmitter is mid-frame.
        c = cyc;
        req_valid = 4'b0010;
        req_data  = 32'h0000_3C00;
        exp_acc(c, 4'b0010);
        exp_lau(c + 1, 2'd1, 8'h3C, 1'b0, 1'b0);
        step(1);
        req_valid = '0;
        step(3);
        chk("mid_frame_active", 32'(active), 32'h1);
        step(1);
        rst = 1'b1;
        step(1);
        chk("mid_reset_outputs",
            {13'h0, tx_start, req_ready, err_timeout, active, data_in,
             parity_en, even_parity, grant_id}, 32'h0);
        step(6);
        rst = 1'b0;
        step(1);

        // All four requesting: order 0,1,2,3,0 every 14 cycles.
        c = cyc;
        req_valid = 4'b1111;
        req_data  = 32'h4332_2110;
        pe = 1'b0;
        ep = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_acc(c + 14 * k, 4'(1 << (k % 4)));
            exp_lau(c + 14 * k + 1, 2'(k % 4), 8'(8'h10 + 8'h11 * (k % 4)),
                    1'b0, 1'b1);
        end
        step(57);
        req_valid = '0;
        step(13);

        // No acknowledge: timeout 16 cycles after start, then next requester.
        c = cyc;
        ack_en    = 1'b0;
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        pe = 1'b1;
        ep = 1'b0;
        exp_acc(c, 4'b0100);
        exp_lau(c + 1, 2'd2, 8'h5A, 1'b1, 1'b0);
        err_q.push_back(c + 17);
        step(1);
        req_valid = '0;
        step(1);
        ack_en    = 1'b1;
        req_valid = 4'b1001;
        req_data  = 32'h9900_0077;
        pe = 1'b0;
        ep = 1'b0;
        exp_acc(c + 20, 4'b1000);
        exp_lau(c + 21, 2'd3, 8'h99, 1'b0, 1'b0);
        exp_acc(c + 34, 4'b0001);
        exp_lau(c + 35, 2'd0, 8'h77, 1'b0, 1'b0);
        step(19);
        req_valid = 4'b0001;
        step(14);
        req_valid = '0;
        step(13);

        // Foreign busy in IDLE blocks the grant until it drops.
        c = cyc;
        force_busy = 1'b1;
        req_valid  = 4'b0001;
        req_data   = 32'h0000_00E7;
        pe = 1'b1;
        ep = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("busy_hold_ready", 32'(req_ready), 32'h0);
            step(1);
        end
        force_busy = 1'b0;
        exp_acc(c + 4, 4'b0001);
        exp_lau(c + 5, 2'd0, 8'hE7, 1'b1, 1'b1);
        step(1);
        req_valid = '0;
        step(13);

        // Zero-gap instance: IDLE right after busy falls.
        c = cyc;
        req_valid0 = 4'b0011;
        req_data   = 32'h0000_C3B2;
        pe = 1'b0;
        ep = 1'b1;
        exp_acc0(c, 4'b0001);
        exp_lau0(c + 1, 2'd0, 8'hB2, 1'b0, 1'b1);
        exp_acc0(c + 12, 4'b0010);
        exp_lau0(c + 13, 2'd1, 8'hC3, 1'b0, 1'b1);
        step(1);
        req_valid0 = 4'b0010;
        step(12);
        req_valid0 = '0;
        step(14);

        chk("accepts_pending", acc_q.size(), 0);
        chk("launches_pending", lau_q.size(), 0);
        chk("timeouts_pending", err_q.size(), 0);
        chk("g0_accepts_pending", acc0_q.size(), 0);
        chk("g0_launches_pending", lau0_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
